digit_scan_mux: RTL and testbench

//  Time-multiplexed digit scanner that sits directly upstream of the nibble-to-7-segment decoder.

---
 rtl/digit_scan_mux.sv | 125 ++++++++++++
 tb/tb_digit_scan_mux.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/digit_scan_mux.sv
// Time-multiplexed hex digit scanner feeding a shared 7-segment decoder.
// Shadow value updates only at frame boundaries so a displayed frame never tears.
module digit_scan_mux #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned PRESCALE = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic                  blank_lz,
  output logic [3:0]            num,
  output logic [DIGITS-1:0]     an_n,
  output logic                  frame_done
);

  localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(PRESCALE - 1);
  localparam logic [IdxW-1:0] IdxMax = IdxW'(DIGITS - 1);

  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0]   shadow_q, shadow_d;
  logic [4*DIGITS-1:0]   pending_q, pending_d;
  logic                  pending_valid_q, pending_valid_d;
  logic [3:0]            num_q, num_d;
  logic [DIGITS-1:0]     an_n_q, an_n_d;
  logic                  frame_done_q, frame_done_d;

  logic                  cnt_wrap;
  logic                  idx_wrap;
  logic                  boundary;
  logic [DIGITS-1:0]     upper_zero;
  logic [DIGITS-1:0]     an_sel;
  logic [3:0]            sel_nib;
  logic                  sel_zero;
  logic                  blanked;
  logic                  acc;

  // Slot and digit counters; loads never touch these.
  always_comb begin
    cnt_wrap = (cnt_q == CntMax);
    idx_wrap = (idx_q == IdxMax);
    boundary = cnt_wrap && idx_wrap;
    cnt_d    = cnt_wrap ? '0 : cnt_q + CntW'(1);
    idx_d    = idx_q;
    if (cnt_wrap) begin
      idx_d = idx_wrap ? '0 : idx_q + IdxW'(1);
    end
  end

  // A load in the boundary cycle itself takes priority over an older pending value.
  always_comb begin
    shadow_d        = shadow_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    if (load) begin
      pending_d       = value;
      pending_valid_d = 1'b1;
    end
    if (boundary) begin
      if (load) begin
        shadow_d = value;
      end else if (pending_valid_q) begin
        shadow_d = pending_q;
      end
      pending_valid_d = 1'b0;
    end
  end

  // upper_zero[i] is set when nibbles i..DIGITS-1 of the shadow are all zero.
  always_comb begin
    upper_zero = '0;
    acc        = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      acc           = acc & (shadow_q[4*i +: 4] == 4'h0);
      upper_zero[i] = acc;
    end
  end

  always_comb begin
    an_sel   = '1;
    sel_nib  = 4'h0;
    sel_zero = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IdxW'(i)) begin
        an_sel[i] = 1'b0;
        sel_nib   = shadow_q[4*i +: 4];
        sel_zero  = upper_zero[i];
      end
    end
    blanked      = blank_lz && (idx_q != '0) && sel_zero;
    an_n_d       = blanked ? '1 : an_sel;
    num_d        = blanked ? 4'h0 : sel_nib;
    frame_done_d = boundary;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q           <= '0;
      idx_q           <= '0;
      shadow_q        <= '0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      num_q           <= 4'h0;
      an_n_q          <= '1;
      frame_done_q    <= 1'b0;
    end else begin
      cnt_q           <= cnt_d;
      idx_q           <= idx_d;
      shadow_q        <= shadow_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      num_q           <= num_d;
      an_n_q          <= an_n_d;
      frame_done_q    <= frame_done_d;
    end
  end

  assign num        = num_q;
  assign an_n       = an_n_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_digit_scan_mux.sv
// Scenario bench for digit_scan_mux (DIGITS=4, PRESCALE=4): per-cycle expected
// slot outputs are queued as stimulus is driven and compared one clock later.
module tb_digit_scan_mux;

  logic        clk;
  logic        reset;
  logic [15:0] value;
  logic        load;
  logic        blank_lz;
  logic [3:0]  num;
  logic [3:0]  an_n;
  logic        frame_done;

  int total;
  int bad;
  int st;
  logic [8:0] sb[$];

  digit_scan_mux #(
    .DIGITS  (4),
    .PRESCALE(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .value     (value),
    .load      (load),
    .blank_lz  (blank_lz),
    .num       (num),
    .an_n      (an_n),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {an_n, num, frame_done} for scan state j given the shadow the scenario holds.
  function automatic logic [8:0] expect_slot(input logic [15:0] sh, input logic bl, input int j);
    int d;
    logic fd;
    logic [3:0] an;
    logic [3:0] nib;
    logic [15:0] upper;
    d     = (j / 4) % 4;
    fd    = ((j % 16) == 15);
    nib   = sh[4*d +: 4];
    upper = sh >> (4 * d);
    an    = 4'b1111;
    an[d] = 1'b0;
    if (bl && d > 0 && upper == 16'h0) begin
      an  = 4'b1111;
      nib = 4'h0;
    end
    return {an, nib, fd};
  endfunction

  task automatic step(input logic ld, input logic [15:0] v, input logic bl,
                      input logic [15:0] sh, input string tag);
    logic [8:0] exp;
    logic [8:0] got;
    load     = ld;
    value    = v;
    blank_lz = bl;
    sb.push_back(expect_slot(sh, bl, st));
    @(negedge clk);
    exp = sb.pop_front();
    got = {an_n, num, frame_done};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s state=%0d an_n/num/fd got=%b/%h/%b want=%b/%h/%b", tag, st,
               got[8:5], got[4:1], got[0], exp[8:5], exp[4:1], exp[0]);
    end
    st++;
  endtask

  // Runs n states of a frame; o1/o2 are load offsets (-1 = none).
  task automatic frame(input logic [15:0] sh, input logic bl, input int o1, input logic [15:0] v1,
                       input int o2, input logic [15:0] v2, input int n, input string tag);
    logic        ld;
    logic [15:0] v;
    for (int k = 0; k < n; k++) begin
      ld = 1'b0;
      v  = 16'hDEAD;
      if (k == o1) begin
        ld = 1'b1;
        v  = v1;
      end
      if (k == o2) begin
        ld = 1'b1;
        v  = v2;
      end
      step(ld, v, bl, sh, tag);
    end
  endtask

  task automatic do_reset(input int n, input string tag);
    reset = 1'b1;
    load  = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      total++;
      if (an_n !== 4'b1111 || num !== 4'h0 || frame_done !== 1'b0) begin
        bad++;
        $display("FAIL %s cycle=%0d an_n/num/fd got=%b/%h/%b want=1111/0/0", tag, k,
                 an_n, num, frame_done);
      end
    end
    reset = 1'b0;
    st    = 0;
  endtask

  task automatic test_reset();
    do_reset(3, "reset_hold");
  endtask

  task automatic test_load();
    frame(16'h0000, 1'b0, 2, 16'h1234, -1, 16'h0, 16, "load_f0");
    frame(16'h1234, 1'b0, -1, 16'h0, -1, 16'h0, 16, "load_f1");
  endtask

  task automatic test_midframe_load();
    frame(16'h1234, 1'b0, 9, 16'hABCD, -1, 16'h0, 16, "mid_old");
    frame(16'hABCD, 1'b0, 2, 16'h1111, 7, 16'h2222, 16, "mid_new");
  endtask

  task automatic test_back_to_back();
    frame(16'h2222, 1'b0, 4, 16'h7777, 15, 16'h5A5A, 16, "two_loads");
    frame(16'h5A5A, 1'b0, 3, 16'h0050, -1, 16'h0, 16, "boundary_load");
  endtask

  task automatic test_blank();
    frame(16'h0050, 1'b1, 5, 16'h0000, -1, 16'h0, 16, "blank_0050");
    frame(16'h0000, 1'b1, -1, 16'h0, -1, 16'h0, 16, "blank_0000");
    frame(16'h0000, 1'b0, 0, 16'h4321, -1, 16'h0, 16, "noblank_0000");
  endtask

  task automatic test_reset_mid();
    frame(16'h4321, 1'b0, 6, 16'h9999, -1, 16'h0, 10, "pre_reset");
    do_reset(2, "reset_mid");
    frame(16'h0000, 1'b0, -1, 16'h0, -1, 16'h0, 16, "post_reset_f0");
    frame(16'h0000, 1'b0, -1, 16'h0, -1, 16'h0, 16, "post_reset_f1");
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    st       = 0;
    reset    = 1'b1;
    load     = 1'b0;
    value    = 16'h0;
    blank_lz = 1'b0;
    test_reset();
    test_load();
    test_midframe_load();
    test_back_to_back();
    test_blank();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
